// File: rtl/msg_tx_arbiter_if.sv
// Bundle of message-source and GPIO-link handshake signals for msg_tx_arbiter.
// master = sources/link side, slave = arbiter side.
interface msg_tx_arbiter_if #(
   parameter int unsigned MSG_W = 128
);
   logic             kb_req;
   logic [MSG_W-1:0] kb_msg;
   logic             kb_grant;
   logic             pre_req;
   logic [MSG_W-1:0] pre_msg;
   logic             pre_grant;
   logic             link_data_ready;
   logic [MSG_W-1:0] link_message_out;
   logic             link_done;
   logic             busy;
   logic             err;
   logic             last_src;

   modport master (
      output kb_req, kb_msg, pre_req, pre_msg, link_done,
      input  kb_grant, pre_grant, link_data_ready, link_message_out, busy, err, last_src
   );

   modport slave (
      input  kb_req, kb_msg, pre_req, pre_msg, link_done,
      output kb_grant, pre_grant, link_data_ready, link_message_out, busy, err, last_src
   );
endinterface

// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter between keyboard and preset message sources feeding the GPIO link,
// with done handshake, timeout/retry and sticky error. ARB_STATS_EN adds send counters.
module msg_tx_arbiter #(
   parameter int unsigned MSG_W          = 128,
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned CNT_W          = 26
) (
   input  logic                  CLOCK_50,
   input  logic                  RESETN,
   msg_tx_arbiter_if.slave       bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]           sent_ok_cnt,
   output logic [15:0]           sent_err_cnt
`endif
);
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0]    RETRY_LAST = RW'(MAX_RETRY);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_WAIT_DROP, S_ERROR} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [RW-1:0]    r_retry;
   logic             r_rr_ptr;
   logic             r_kb_grant;
   logic             r_pre_grant;
   logic             r_ready;
   logic [MSG_W-1:0] r_msg;
   logic             r_err;
   logic             r_last_src;
   logic             r_sync1, r_sync2, r_sync3;
   logic             w_done_rise;
`ifdef ARB_STATS_EN
   logic [15:0]      r_ok_cnt, r_err_cnt;
`endif

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= bus.link_done;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_done_rise = r_sync2 & ~r_sync3;

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_rr_ptr    <= 1'b0;
         r_kb_grant  <= 1'b0;
         r_pre_grant <= 1'b0;
         r_ready     <= 1'b0;
         r_msg       <= '0;
         r_err       <= 1'b0;
         r_last_src  <= 1'b0;
`ifdef ARB_STATS_EN
         r_ok_cnt    <= '0;
         r_err_cnt   <= '0;
`endif
      end else begin
         r_kb_grant  <= 1'b0;
         r_pre_grant <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.kb_req || bus.pre_req) begin
                  if (bus.kb_req && (!bus.pre_req || !r_rr_ptr)) begin
                     r_kb_grant <= 1'b1;
                     r_msg      <= bus.kb_msg;
                     r_last_src <= 1'b0;
                     r_rr_ptr   <= 1'b1;
                  end else begin
                     r_pre_grant <= 1'b1;
                     r_msg       <= bus.pre_msg;
                     r_last_src  <= 1'b1;
                     r_rr_ptr    <= 1'b0;
                  end
                  r_err   <= 1'b0;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               r_cnt   <= '0;
               r_retry <= '0;
               r_ready <= 1'b1;
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (w_done_rise) begin
                  r_ready <= 1'b0;
                  r_state <= S_WAIT_DROP;
`ifdef ARB_STATS_EN
                  r_ok_cnt <= r_ok_cnt + 16'd1;
`endif
               end else if (r_cnt == TO_LAST) begin
                  r_ready <= 1'b0;
                  if (r_retry == RETRY_LAST) begin
                     r_err   <= 1'b1;
                     r_state <= S_ERROR;
`ifdef ARB_STATS_EN
                     r_err_cnt <= r_err_cnt + 16'd1;
`endif
                  end else begin
                     r_retry <= r_retry + RW'(1);
                     r_cnt   <= '0;
                  end
               end else begin
                  // the 1-cycle gap after a retry counts toward the next attempt
                  r_ready <= 1'b1;
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_WAIT_DROP: if (!r_sync2) r_state <= S_IDLE;
            S_ERROR:     r_state <= S_IDLE;
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.kb_grant         = r_kb_grant;
   assign bus.pre_grant        = r_pre_grant;
   assign bus.link_data_ready  = r_ready;
   assign bus.link_message_out = r_msg;
   assign bus.busy             = (r_state != S_IDLE);
   assign bus.err              = r_err;
   assign bus.last_src         = r_last_src;
`ifdef ARB_STATS_EN
   assign sent_ok_cnt  = r_ok_cnt;
   assign sent_err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Directed bench for msg_tx_arbiter: cycle table plus hand sequences for timeout,
// long done, and mid-transfer reset. Build with ARB_STATS_EN to also check counters.
module tb_msg_tx_arbiter;
   localparam logic [127:0] KB_MSG  = 128'h4B45_5942_4F41_5244_2048_454C_4C4F_3A29;
   localparam logic [127:0] PRE_MSG = 128'h5052_4553_4554_2045_4D4F_4A49_203C_333E;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   msg_tx_arbiter_if #(.MSG_W(128)) bif ();
`ifdef ARB_STATS_EN
   logic [15:0] ok_cnt, err_cnt;
`endif

   msg_tx_arbiter #(.MSG_W(128), .TIMEOUT_CYCLES(10), .MAX_RETRY(2), .CNT_W(4)) dut (
      .CLOCK_50(clk),
      .RESETN  (rst_n),
      .bus     (bif)
`ifdef ARB_STATS_EN
      ,
      .sent_ok_cnt (ok_cnt),
      .sent_err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       kb, pre, done;
      logic       kg, pg, rdy, busy, last, err;
      logic [1:0] msg;
   } vec_t;

   vec_t tbl[17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] msg_of(input logic [1:0] code);
      return (code == 2'd1) ? KB_MSG : (code == 2'd2) ? PRE_MSG : '0;
   endfunction

   task automatic finish_xfer(input string tag);
      int unsigned n;
      bif.link_done = 1'b1;
      n = 0;
      while (bif.link_data_ready && n < 8) begin tick(); n++; end
      chk({tag, " ready drop"}, bif.link_data_ready, 1'b0);
      chk({tag, " drop latency"}, 128'(n <= 4), 1'b1);
      bif.link_done = 1'b0;
      n = 0;
      while (bif.busy && n < 8) begin tick(); n++; end
      chk({tag, " back idle"}, bif.busy, 1'b0);
   endtask

   initial begin
      logic [31:0] rdy_seen, rdy_exp;
      int unsigned n;
      logic seen_grant;

      //            kb   pre  done kg   pg   rdy  busy last err  msg
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd1};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd1};
      tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd1};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1};
      tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'd2};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,2'd2};
      tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,2'd2};
      tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,2'd2};
      tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd2};
      tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd2};
      tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2};
      tbl[15] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd1};

      bif.kb_req = 1'b0; bif.pre_req = 1'b0; bif.link_done = 1'b0;
      bif.kb_msg = KB_MSG; bif.pre_msg = PRE_MSG;
      repeat (2) @(posedge clk);
      #2;
      chk("reset ready", bif.link_data_ready, 1'b0);
      chk("reset msg", bif.link_message_out, '0);
      chk("reset busy", bif.busy, 1'b0);
      chk("reset err", bif.err, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         bif.kb_req = tbl[i].kb; bif.pre_req = tbl[i].pre; bif.link_done = tbl[i].done;
         tick();
         chk($sformatf("row%0d kb_grant", i), bif.kb_grant, tbl[i].kg);
         chk($sformatf("row%0d pre_grant", i), bif.pre_grant, tbl[i].pg);
         chk($sformatf("row%0d ready", i), bif.link_data_ready, tbl[i].rdy);
         chk($sformatf("row%0d busy", i), bif.busy, tbl[i].busy);
         chk($sformatf("row%0d last_src", i), bif.last_src, tbl[i].last);
         chk($sformatf("row%0d err", i), bif.err, tbl[i].err);
         chk($sformatf("row%0d msg", i), bif.link_message_out, msg_of(tbl[i].msg));
      end

      // timeout: windows of 10, 9, 9 high cycles with 1-cycle gaps, then ERROR
      rdy_seen = '0; rdy_exp = '0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         rdy_seen[i] = bif.link_data_ready;
         rdy_exp[i]  = (i != 10 && i != 20 && i != 30);
         if (i == 29) chk("err before expiry", bif.err, 1'b0);
      end
      chk("retry ready pattern", rdy_seen, rdy_exp);
      chk("error state err", bif.err, 1'b1);
      chk("error state busy", bif.busy, 1'b1);
      tick();
      chk("post error idle", bif.busy, 1'b0);
      chk("err sticky", bif.err, 1'b1);

      bif.pre_req = 1'b1;
      tick();
      chk("regrant pre_grant", bif.pre_grant, 1'b1);
      chk("regrant clears err", bif.err, 1'b0);
      bif.pre_req = 1'b0;
      tick();
      chk("regrant ready", bif.link_data_ready, 1'b1);

      // long done: held high, the next request must wait for it to fall
      bif.link_done = 1'b1;
      n = 0;
      while (bif.link_data_ready && n < 8) begin tick(); n++; end
      chk("long done ready drop", bif.link_data_ready, 1'b0);
      bif.kb_req = 1'b1;
      seen_grant = 1'b0;
      repeat (8) begin tick(); seen_grant |= bif.kb_grant; end
      chk("no grant while done high", seen_grant, 1'b0);
      chk("stuck in wait_drop", bif.busy, 1'b1);
      bif.link_done = 1'b0;
      n = 0;
      while (!bif.kb_grant && n < 8) begin tick(); n++; end
      chk("grant after done falls", bif.kb_grant, 1'b1);
      bif.kb_req = 1'b0;
      repeat (3) tick();
      chk("second msg pending ready", bif.link_data_ready, 1'b1);
      chk("second msg out", bif.link_message_out, KB_MSG);

      // mid-SEND reset with both requests pending
      bif.kb_req = 1'b1; bif.pre_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async reset ready", bif.link_data_ready, 1'b0);
      chk("async reset busy", bif.busy, 1'b0);
      chk("async reset msg", bif.link_message_out, '0);
      chk("async reset last_src", bif.last_src, 1'b0);
`ifdef ARB_STATS_EN
      chk("reset ok_cnt", ok_cnt, 16'd0);
      chk("reset err_cnt", err_cnt, 16'd0);
`endif
      #2 rst_n = 1'b1;
      tick();
      chk("post reset kb first", bif.kb_grant, 1'b1);
      chk("post reset no pre", bif.pre_grant, 1'b0);
      bif.kb_req = 1'b0;
      tick();
      finish_xfer("kb after reset");
      tick();
      chk("pending pre granted", bif.pre_grant, 1'b1);
      chk("pending pre last_src", bif.last_src, 1'b1);
      chk("pending pre msg", bif.link_message_out, PRE_MSG);
      bif.pre_req = 1'b0;
      tick();
      finish_xfer("pre after reset");
      chk("msg held after done", bif.link_message_out, PRE_MSG);
`ifdef ARB_STATS_EN
      chk("final ok_cnt", ok_cnt, 16'd2);
      chk("final err_cnt", err_cnt, 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
